// File: rtl/micron_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between NREQ requesters.
module micron_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 16
) (
  input  logic              clk50MHz,
  input  logic              rst_L,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*2-1:0] req_burst,
  input  logic [NREQ-1:0]   req_we,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   beat,
  output logic [NREQ-1:0]   done,
  output logic              ctrl_start,
  output logic [AW-1:0]     ctrl_addr,
  output logic [1:0]        ctrl_burst,
  output logic              ctrl_we,
  input  logic              ctrl_busy,
  input  logic              ctrl_beat
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, XFER, GAP} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      burst_q, burst_d;
  logic            we_q, we_d;
  logic [4:0]      cnt_q, cnt_d;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [1:0]      burst_arr [NREQ];
  logic            found;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   j;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*AW +: AW];
    assign burst_arr[g] = req_burst[g*2 +: 2];
  end

  function automatic logic [4:0] burst_len(input logic [1:0] code);
    case (code)
      2'b00:   burst_len = 5'd1;
      2'b01:   burst_len = 5'd4;
      2'b10:   burst_len = 5'd8;
      default: burst_len = 5'd16;
    endcase
  endfunction

  always_ff @(posedge clk50MHz or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    done_d  = '0;
    addr_d  = addr_q;
    burst_d = burst_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    found   = 1'b0;
    sel     = '0;
    j       = '0;
    // Rotating priority: scan from ptr upward, wrapping modulo NREQ.
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = IW'((32'(ptr_q) + i) % NREQ);
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = j;
      end
    end
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d      = sel;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          addr_d       = addr_arr[sel];
          burst_d      = burst_arr[sel];
          we_d         = req_we[sel];
          state_d      = START;
        end
      end
      START: begin
        if (ctrl_start) begin
          cnt_d   = burst_len(burst_q);
          state_d = XFER;
        end
      end
      XFER: begin
        if (ctrl_beat) begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d         = GAP;
            ptr_d           = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            done_d[owner_q] = 1'b1;
          end
        end
      end
      GAP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_start = (state_q == START) && !ctrl_busy;
    beat       = (state_q == XFER && ctrl_beat) ? grant_q : '0;
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign ctrl_addr  = addr_q;
  assign ctrl_burst = burst_q;
  assign ctrl_we    = we_q;

endmodule

// File: tb/tb_micron_arbiter.sv
module tb_micron_arbiter;

  logic        clk50MHz = 1'b0;
  logic        rst_L = 1'b1;
  logic [2:0]  req = '0;
  logic [47:0] req_addr;
  logic [5:0]  req_burst;
  logic [2:0]  req_we = '0;
  logic [2:0]  grant, beat, done;
  logic        ctrl_start;
  logic [15:0] ctrl_addr;
  logic [1:0]  ctrl_burst;
  logic        ctrl_we;
  logic        ctrl_busy = 1'b0;
  logic        ctrl_beat = 1'b0;

  logic [15:0] a_arr [3];
  logic [1:0]  b_arr [3];

  int checks = 0;
  int failures = 0;

  assign req_addr  = {a_arr[2], a_arr[1], a_arr[0]};
  assign req_burst = {b_arr[2], b_arr[1], b_arr[0]};

  micron_arbiter #(.NREQ(3), .AW(16)) dut (
    .clk50MHz  (clk50MHz),
    .rst_L     (rst_L),
    .req       (req),
    .req_addr  (req_addr),
    .req_burst (req_burst),
    .req_we    (req_we),
    .grant     (grant),
    .beat      (beat),
    .done      (done),
    .ctrl_start(ctrl_start),
    .ctrl_addr (ctrl_addr),
    .ctrl_burst(ctrl_burst),
    .ctrl_we   (ctrl_we),
    .ctrl_busy (ctrl_busy),
    .ctrl_beat (ctrl_beat)
  );

  always #10 clk50MHz = ~clk50MHz;

  task automatic cyc;
    @(posedge clk50MHz);
    #2;
  endtask

  task automatic set_req(input logic [1:0] i, input logic [15:0] a, input logic [1:0] b, input logic w);
    a_arr[i]  = a;
    b_arr[i]  = b;
    req_we[i] = w;
  endtask

  task automatic do_reset;
    req       = '0;
    ctrl_beat = 1'b0;
    ctrl_busy = 1'b0;
    rst_L     = 1'b0;
    #5;
    rst_L     = 1'b1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    #1 rst_L = 1'b0;
    #4;
    checks++;
    if ({grant, beat, done, ctrl_start} !== 10'b0) begin
      failures++;
      $display("FAIL reset_flags got grant=%b beat=%b done=%b start=%b exp all 0", grant, beat, done, ctrl_start);
    end
    checks++;
    if ({ctrl_addr, ctrl_burst, ctrl_we} !== 19'b0) begin
      failures++;
      $display("FAIL reset_ctrl got addr=%h burst=%b we=%b exp 0", ctrl_addr, ctrl_burst, ctrl_we);
    end
    cyc();
    rst_L = 1'b1;
    cyc();
    checks++;
    if (grant !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle_grant got=%b exp=000", grant);
    end
  endtask

  task automatic test_single;
    set_req(2'd0, 16'hFFFA, 2'b00, 1'b1);
    req = 3'b001;
    cyc();
    checks++;
    if (grant !== 3'b001) begin
      failures++;
      $display("FAIL single_grant got=%b exp=001", grant);
    end
    checks++;
    if (ctrl_start !== 1'b1 || ctrl_addr !== 16'hFFFA || ctrl_we !== 1'b1 || ctrl_burst !== 2'b00) begin
      failures++;
      $display("FAIL single_ctrl got start=%b addr=%h we=%b burst=%b exp 1 FFFA 1 00",
               ctrl_start, ctrl_addr, ctrl_we, ctrl_burst);
    end
    cyc();
    checks++;
    if (ctrl_start !== 1'b0) begin
      failures++;
      $display("FAIL single_start_once got=%b exp=0", ctrl_start);
    end
    ctrl_beat = 1'b1;
    #1;
    checks++;
    if (beat !== 3'b001) begin
      failures++;
      $display("FAIL single_beat got=%b exp=001", beat);
    end
    cyc();
    ctrl_beat = 1'b0;
    req = 3'b000;
    checks++;
    if (done !== 3'b001 || grant !== 3'b001 || beat !== 3'b000) begin
      failures++;
      $display("FAIL single_done got done=%b grant=%b beat=%b exp 001 001 000", done, grant, beat);
    end
    cyc();
    checks++;
    if (done !== 3'b000 || grant !== 3'b000) begin
      failures++;
      $display("FAIL single_release got done=%b grant=%b exp 000 000", done, grant);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0]  exp_g;
    logic [15:0] exp_a;
    int nb;
    do_reset();
    set_req(2'd0, 16'h1000, 2'b01, 1'b0);
    set_req(2'd1, 16'h2000, 2'b01, 1'b0);
    set_req(2'd2, 16'h3000, 2'b01, 1'b0);
    req = 3'b111;
    for (int o = 0; o < 3; o++) begin
      exp_g = 3'b001 << o;
      exp_a = 16'h1000 * 16'(o + 1);
      cyc();
      checks++;
      if (grant !== exp_g || ctrl_addr !== exp_a) begin
        failures++;
        $display("FAIL rr_grant%0d got grant=%b addr=%h exp %b %h", o, grant, ctrl_addr, exp_g, exp_a);
      end
      cyc();
      nb = 0;
      for (int b = 0; b < 4; b++) begin
        ctrl_beat = 1'b1;
        #1;
        if (beat === exp_g) nb++;
        cyc();
      end
      ctrl_beat = 1'b0;
      checks++;
      if (nb != 4 || done !== exp_g) begin
        failures++;
        $display("FAIL rr_burst%0d got beats=%0d done=%b exp 4 %b", o, nb, done, exp_g);
      end
      if (o < 2) req[o] = 1'b0;
      else req[0] = 1'b1;
      cyc();
      checks++;
      if (grant !== 3'b000) begin
        failures++;
        $display("FAIL rr_gap%0d got grant=%b exp=000", o, grant);
      end
    end
    cyc();
    checks++;
    if (grant !== 3'b001) begin
      failures++;
      $display("FAIL rr_rerequest got grant=%b exp=001", grant);
    end
  endtask

  task automatic test_busy;
    int bad;
    do_reset();
    ctrl_busy = 1'b1;
    set_req(2'd1, 16'hBEEF, 2'b00, 1'b0);
    req = 3'b010;
    cyc();
    a_arr[1] = 16'h0000;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (ctrl_start !== 1'b0 || ctrl_addr !== 16'hBEEF || grant !== 3'b010) bad++;
      cyc();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_hold got bad_cycles=%0d exp=0", bad);
    end
    ctrl_busy = 1'b0;
    #1;
    checks++;
    if (ctrl_start !== 1'b1) begin
      failures++;
      $display("FAIL busy_start got=%b exp=1", ctrl_start);
    end
    cyc();
    checks++;
    if (ctrl_start !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_once got=%b exp=0", ctrl_start);
    end
    ctrl_beat = 1'b1;
    cyc();
    ctrl_beat = 1'b0;
    req = 3'b000;
    checks++;
    if (done !== 3'b010) begin
      failures++;
      $display("FAIL busy_done got=%b exp=010", done);
    end
    cyc();
  endtask

  task automatic test_long_burst;
    int bad;
    do_reset();
    set_req(2'd2, 16'h4444, 2'b11, 1'b1);
    req = 3'b100;
    cyc();
    cyc();
    bad = 0;
    for (int b = 0; b < 16; b++) begin
      for (int g = 0; g < b % 3; g++) begin
        ctrl_beat = 1'b0;
        cyc();
        if (done !== 3'b000 || grant !== 3'b100) bad++;
      end
      ctrl_beat = 1'b1;
      if (b == 5) begin
        set_req(2'd1, 16'h2222, 2'b00, 1'b0);
        req[1] = 1'b1;
      end
      cyc();
      if (b < 15 && (done !== 3'b000 || grant !== 3'b100)) bad++;
    end
    ctrl_beat = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL long_early got bad_cycles=%0d exp=0", bad);
    end
    checks++;
    if (done !== 3'b100) begin
      failures++;
      $display("FAIL long_done got=%b exp=100", done);
    end
    req[2] = 1'b0;
    cyc();
    checks++;
    if (grant !== 3'b000) begin
      failures++;
      $display("FAIL long_dead got grant=%b exp=000", grant);
    end
    cyc();
    checks++;
    if (grant !== 3'b010) begin
      failures++;
      $display("FAIL long_next got grant=%b exp=010", grant);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_req(2'd0, 16'h5555, 2'b10, 1'b1);
    req = 3'b001;
    cyc();
    cyc();
    for (int b = 0; b < 2; b++) begin
      ctrl_beat = 1'b1;
      cyc();
    end
    #1;
    checks++;
    if (beat !== 3'b001) begin
      failures++;
      $display("FAIL rstmid_beat3 got=%b exp=001", beat);
    end
    rst_L = 1'b0;
    #1;
    checks++;
    if ({grant, beat, done, ctrl_start} !== 10'b0 || {ctrl_addr, ctrl_burst, ctrl_we} !== 19'b0) begin
      failures++;
      $display("FAIL rstmid_clear got grant=%b beat=%b done=%b start=%b addr=%h exp all 0",
               grant, beat, done, ctrl_start, ctrl_addr);
    end
    ctrl_beat = 1'b0;
    req = 3'b110;
    cyc();
    checks++;
    if (done !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_nodone got=%b exp=000", done);
    end
    rst_L = 1'b1;
    cyc();
    checks++;
    if (grant !== 3'b010) begin
      failures++;
      $display("FAIL rstmid_regrant got=%b exp=010", grant);
    end
  endtask

  task automatic test_stray_and_drop;
    int bad;
    int nb;
    do_reset();
    ctrl_beat = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (beat !== 3'b000 || done !== 3'b000 || grant !== 3'b000) bad++;
      cyc();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stray_idle got bad_cycles=%0d exp=0", bad);
    end
    ctrl_beat = 1'b0;
    set_req(2'd0, 16'h7777, 2'b01, 1'b1);
    req = 3'b001;
    cyc();
    cyc();
    nb = 0;
    for (int b = 0; b < 4; b++) begin
      ctrl_beat = 1'b1;
      #1;
      if (beat === 3'b001) nb++;
      if (b == 0) req[0] = 1'b0;
      cyc();
    end
    ctrl_beat = 1'b0;
    checks++;
    if (nb != 4 || done !== 3'b001) begin
      failures++;
      $display("FAIL drop_complete got beats=%0d done=%b exp 4 001", nb, done);
    end
    cyc();
    checks++;
    if (grant !== 3'b000 || done !== 3'b000) begin
      failures++;
      $display("FAIL drop_idle got grant=%b done=%b exp 000 000", grant, done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_long_burst();
    test_reset_mid();
    test_stray_and_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
